// File: rtl/voice_sample_mixer_pkg.sv
// Shared constants and FSM encoding
// for the voice sample mixer.
package voice_mixer_pkg;

  localparam int DEF_SAMPLE_W = 18;
  localparam int SAMPLE_MAX = (1 << (DEF_SAMPLE_W - 1)) - 1;
  localparam int SAMPLE_MIN = -(1 << (DEF_SAMPLE_W - 1));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_SUM  = 3'd3,
    S_SAT  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/voice_sample_mixer_if.sv
// Codec-side and voice-side signals
// of the voice sample mixer.
interface voice_sample_mixer_if
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = DEF_SAMPLE_W
);

  logic                         play_enable;
  logic                         codec_sample_request;
  logic                         generate_next_sample;
  logic [NUM_VOICES-1:0]        voice_sample_ready;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples;
  logic signed [SAMPLE_W-1:0]   mixed_sample;
  logic                         mixed_valid;
  logic                         overrun;
  logic                         timeout_flag;

  modport master (
    input  play_enable,
    input  codec_sample_request,
    input  voice_sample_ready,
    input  voice_samples,
    output generate_next_sample,
    output mixed_sample,
    output mixed_valid,
    output overrun,
    output timeout_flag
  );

  modport slave (
    output play_enable,
    output codec_sample_request,
    output voice_sample_ready,
    output voice_samples,
    input  generate_next_sample,
    input  mixed_sample,
    input  mixed_valid,
    input  overrun,
    input  timeout_flag
  );

endinterface

// File: rtl/voice_sample_mixer_sat_shift_clamp.sv
// Arithmetic right shift followed by
// saturation down to the output width.
module sat_shift_clamp #(
  parameter int ACC_W = 21,
  parameter int OUT_W = 18,
  parameter int SHIFT = 2
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] sample
);

  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] LO = ~HI;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted > HI)
      sample = HI[OUT_W-1:0];
    else if (shifted < LO)
      sample = LO[OUT_W-1:0];
    else
      sample = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/voice_sample_mixer.sv
// Requests one sample from every voice per
// codec request, sums, scales and saturates.
module voice_sample_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES     = 3,
  parameter int SAMPLE_W       = DEF_SAMPLE_W,
  parameter int SHIFT          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset,
  voice_sample_mixer_if.master bus
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W =
    (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [NUM_VOICES-1:0] ALL = '1;

  state_t                     state;
  logic [NUM_VOICES-1:0]      mask;
  logic [NUM_VOICES-1:0]      take;
  logic [NUM_VOICES-1:0]      mask_nxt;
  logic signed [SAMPLE_W-1:0] cap [NUM_VOICES];
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    addend;
  logic signed [SAMPLE_W-1:0] sat_out;
  logic [CNT_W-1:0]           wait_cnt;
  logic [IDX_W-1:0]           idx;
  logic                       pending;
  logic                       req_any;

  assign take     = bus.voice_sample_ready & ~mask;
  assign mask_nxt = mask | take;
  assign req_any  = bus.codec_sample_request | pending;

  // voices that never answered add nothing
  always_comb begin
    addend = '0;
    if (mask[idx])
      addend = ACC_W'(cap[idx]);
  end

  sat_shift_clamp #(
    .ACC_W (ACC_W),
    .OUT_W (SAMPLE_W),
    .SHIFT (SHIFT)
  ) u_clamp (
    .acc    (acc),
    .sample (sat_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mask     <= '0;
      cap      <= '{default: '0};
      acc      <= '0;
      wait_cnt <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      bus.generate_next_sample <= 1'b0;
      bus.mixed_sample         <= '0;
      bus.mixed_valid          <= 1'b0;
      bus.overrun              <= 1'b0;
      bus.timeout_flag         <= 1'b0;
    end else begin
      bus.generate_next_sample <= 1'b0;
      bus.mixed_valid          <= 1'b0;
      bus.overrun              <= 1'b0;

      if (state != S_IDLE && bus.codec_sample_request) begin
        if (pending)
          bus.overrun <= 1'b1;
        else
          pending <= 1'b1;
      end

      if (state == S_REQ || state == S_WAIT) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (take[i])
            cap[i] <= bus.voice_samples[i*SAMPLE_W +: SAMPLE_W];
        mask <= mask_nxt;
      end

      unique case (state)
        S_IDLE: begin
          if (req_any) begin
            // a fresh request alongside a pended one stays pended
            pending <= pending & bus.codec_sample_request;
            acc     <= '0;
            if (bus.play_enable) begin
              state    <= S_REQ;
              mask     <= '0;
              wait_cnt <= '0;
              bus.generate_next_sample <= 1'b1;
            end else begin
              // silence: saturate a cleared accumulator
              state <= S_SAT;
            end
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (mask_nxt == ALL) begin
            state <= S_SUM;
            idx   <= '0;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.timeout_flag <= 1'b1;
            state <= S_SUM;
            idx   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SUM: begin
          acc <= acc + addend;
          idx <= idx + 1'b1;
          if (idx == IDX_W'(NUM_VOICES - 1))
            state <= S_SAT;
        end
        S_SAT: begin
          bus.mixed_sample <= sat_out;
          bus.mixed_valid  <= 1'b1;
          state <= S_OUT;
        end
        S_OUT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_sample_mixer.sv
// Directed-vector bench for the voice sample mixer
// and its shift/saturate stage.
`timescale 1ns/1ps
module tb_voice_sample_mixer;
  import voice_mixer_pkg::*;

  localparam int NV = 3;
  localparam int SW = 18;

  typedef struct {
    int cyc;
    int v;
    int val;
  } rdy_ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  voice_sample_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW)) bus ();
  voice_sample_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW)) bus0 ();

  voice_sample_mixer #(
    .NUM_VOICES(NV), .SAMPLE_W(SW),
    .SHIFT(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  voice_sample_mixer #(
    .NUM_VOICES(NV), .SAMPLE_W(SW),
    .SHIFT(0), .TIMEOUT_CYCLES(64)
  ) dut_s0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  logic signed [20:0] u_acc;
  logic signed [SW-1:0] u_out;

  sat_shift_clamp #(
    .ACC_W(21), .OUT_W(SW), .SHIFT(2)
  ) u_clamp (
    .acc(u_acc), .sample(u_out)
  );

  int reqq[$];
  int rstq[$];
  rdy_ev_t evq[$];
  bit sel;
  logic play_en = 1'b1;

  int gns_cyc[$];
  int val_cyc[$];
  int ovr_cyc[$];
  logic signed [SW-1:0] val_smp[$];
  int to_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_ev(input int c, input int v,
                        input int val);
    rdy_ev_t e;
    e.cyc = c;
    e.v = v;
    e.val = val;
    evq.push_back(e);
  endtask

  task automatic clear_stim();
    reqq.delete();
    rstq.delete();
    evq.delete();
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int second_of(input int q[$]);
    return (q.size() > 1) ? q[1] : -1;
  endfunction

  // cycle 0 is driven at the current time; outputs observed from cycle 1
  task automatic run_window(input int n);
    logic [NV-1:0] rdy;
    logic [NV*SW-1:0] smp;
    logic req, rst, g, mv, ov, tf;
    logic signed [SW-1:0] ms;
    gns_cyc.delete();
    val_cyc.delete();
    val_smp.delete();
    ovr_cyc.delete();
    to_cyc = -1;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) tick();
      req = 1'b0;
      rst = 1'b0;
      rdy = '0;
      smp = '0;
      foreach (reqq[k]) if (reqq[k] == c) req = 1'b1;
      foreach (rstq[k]) if (rstq[k] == c) rst = 1'b1;
      foreach (evq[k]) begin
        if (evq[k].cyc == c) begin
          rdy[evq[k].v] = 1'b1;
          smp[evq[k].v*SW +: SW] = SW'(evq[k].val);
        end
      end
      reset = rst;
      bus.play_enable = play_en;
      bus0.play_enable = play_en;
      bus.codec_sample_request = req;
      bus0.codec_sample_request = req;
      bus.voice_sample_ready = rdy;
      bus0.voice_sample_ready = rdy;
      bus.voice_samples = smp;
      bus0.voice_samples = smp;
      if (c > 0) begin
        g  = sel ? bus0.generate_next_sample
                 : bus.generate_next_sample;
        mv = sel ? bus0.mixed_valid : bus.mixed_valid;
        ov = sel ? bus0.overrun : bus.overrun;
        tf = sel ? bus0.timeout_flag : bus.timeout_flag;
        ms = sel ? bus0.mixed_sample : bus.mixed_sample;
        if (g) gns_cyc.push_back(c);
        if (ov) ovr_cyc.push_back(c);
        if (tf && to_cyc < 0) to_cyc = c;
        if (mv) begin
          val_cyc.push_back(c);
          val_smp.push_back(ms);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.play_enable = 1'b1;
    bus0.play_enable = 1'b1;
    bus.codec_sample_request = 1'b1;
    bus0.codec_sample_request = 1'b1;
    bus.voice_sample_ready = '0;
    bus0.voice_sample_ready = '0;
    bus.voice_samples = '0;
    bus0.voice_samples = '0;
    reset = 1'b1;
    tick();
    tick();
    checks += 6;
    if (bus.generate_next_sample !== 1'b0) begin
      errors++;
      $display("FAIL reset_gns: got %b want 0",
               bus.generate_next_sample);
    end
    if (bus.mixed_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", bus.mixed_valid);
    end
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    end
    if (bus.timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout: got %b want 0",
               bus.timeout_flag);
    end
    if (bus.mixed_sample !== '0) begin
      errors++;
      $display("FAIL reset_sample: got %0d want 0",
               bus.mixed_sample);
    end
    if (bus0.mixed_sample !== '0) begin
      errors++;
      $display("FAIL reset_sample_s0: got %0d want 0",
               bus0.mixed_sample);
    end
    bus.codec_sample_request = 1'b0;
    bus0.codec_sample_request = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    logic signed [SW-1:0] exp [5];
    logic signed [20:0] vin [5];
    vin[0] = 21'sd10000;   exp[0] = 18'sd2500;
    vin[1] = 21'sd524284;  exp[1] = 18'sd131071;
    vin[2] = 21'sd524288;  exp[2] = 18'sd131071;
    vin[3] = -21'sd600000; exp[3] = -18'sd131072;
    vin[4] = -21'sd7;      exp[4] = -18'sd2;
    for (int i = 0; i < 5; i++) begin
      u_acc = vin[i];
      #1;
      checks++;
      if (u_out !== exp[i]) begin
        errors++;
        $display("FAIL clamp_%0d: got %0d want %0d",
                 i, u_out, exp[i]);
      end
    end
  endtask

  task automatic test_nominal();
    clear_stim();
    sel = 1'b0;
    reqq.push_back(0);
    add_ev(3, 0, 4000);
    add_ev(3, 1, 8000);
    add_ev(3, 2, -2000);
    run_window(12);
    checks += 4;
    if (first_of(gns_cyc) != 1) begin
      errors++;
      $display("FAIL nominal_gns_cycle: got %0d want 1",
               first_of(gns_cyc));
    end
    if (val_cyc.size() != 1) begin
      errors++;
      $display("FAIL nominal_valid_count: got %0d want 1",
               val_cyc.size());
    end
    if (first_of(val_cyc) != 8) begin
      errors++;
      $display("FAIL nominal_valid_cycle: got %0d want 8",
               first_of(val_cyc));
    end
    if (val_smp.size() == 0 || val_smp[0] !== 18'sd2500) begin
      errors++;
      $display("FAIL nominal_sample: got %0d want 2500",
               (val_smp.size() > 0) ? val_smp[0] : 'x);
    end
  endtask

  task automatic test_staggered();
    clear_stim();
    sel = 1'b0;
    reqq.push_back(0);
    add_ev(2, 0, 1000);
    add_ev(5, 1, 1000);
    add_ev(6, 0, 9999);
    add_ev(9, 2, 1000);
    run_window(18);
    checks += 3;
    if (val_cyc.size() != 1) begin
      errors++;
      $display("FAIL stagger_valid_count: got %0d want 1",
               val_cyc.size());
    end
    if (first_of(val_cyc) != 14) begin
      errors++;
      $display("FAIL stagger_valid_cycle: got %0d want 14",
               first_of(val_cyc));
    end
    if (val_smp.size() == 0 || val_smp[0] !== 18'sd750) begin
      errors++;
      $display("FAIL stagger_sample: got %0d want 750",
               (val_smp.size() > 0) ? val_smp[0] : 'x);
    end
  endtask

  task automatic test_saturation();
    logic signed [SW-1:0] hi, lo;
    hi = SW'(SAMPLE_MAX);
    lo = SW'(SAMPLE_MIN);
    clear_stim();
    sel = 1'b1;
    reqq.push_back(0);
    for (int v = 0; v < NV; v++) add_ev(2, v, SAMPLE_MAX);
    run_window(10);
    checks += 2;
    if (first_of(val_cyc) != 7) begin
      errors++;
      $display("FAIL sat_hi_cycle: got %0d want 7",
               first_of(val_cyc));
    end
    if (val_smp.size() == 0 || val_smp[0] !== hi) begin
      errors++;
      $display("FAIL sat_hi_sample: got %0d want %0d",
               (val_smp.size() > 0) ? val_smp[0] : 'x, hi);
    end
    clear_stim();
    reqq.push_back(0);
    for (int v = 0; v < NV; v++) add_ev(2, v, SAMPLE_MIN);
    run_window(10);
    checks += 2;
    if (first_of(val_cyc) != 7) begin
      errors++;
      $display("FAIL sat_lo_cycle: got %0d want 7",
               first_of(val_cyc));
    end
    if (val_smp.size() == 0 || val_smp[0] !== lo) begin
      errors++;
      $display("FAIL sat_lo_sample: got %0d want %0d",
               (val_smp.size() > 0) ? val_smp[0] : 'x, lo);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_stim();
    sel = 1'b0;
    reqq.push_back(0);
    reqq.push_back(3);
    reqq.push_back(5);
    add_ev(10, 0, 100);
    add_ev(10, 1, 200);
    add_ev(10, 2, 300);
    for (int v = 0; v < NV; v++) add_ev(18, v, 400);
    run_window(28);
    checks += 7;
    if (ovr_cyc.size() != 1 || first_of(ovr_cyc) != 6) begin
      errors++;
      $display("FAIL b2b_overrun: got n=%0d at %0d want n=1 at 6",
               ovr_cyc.size(), first_of(ovr_cyc));
    end
    if (val_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d want 2",
               val_cyc.size());
    end
    if (first_of(val_cyc) != 15) begin
      errors++;
      $display("FAIL b2b_valid1_cycle: got %0d want 15",
               first_of(val_cyc));
    end
    if (second_of(val_cyc) != 23) begin
      errors++;
      $display("FAIL b2b_valid2_cycle: got %0d want 23",
               second_of(val_cyc));
    end
    if (second_of(gns_cyc) != 17) begin
      errors++;
      $display("FAIL b2b_gns2_cycle: got %0d want 17",
               second_of(gns_cyc));
    end
    if (val_smp.size() < 1 || val_smp[0] !== 18'sd150) begin
      errors++;
      $display("FAIL b2b_sample1: got %0d want 150",
               (val_smp.size() > 0) ? val_smp[0] : 'x);
    end
    if (val_smp.size() < 2 || val_smp[1] !== 18'sd300) begin
      errors++;
      $display("FAIL b2b_sample2: got %0d want 300",
               (val_smp.size() > 1) ? val_smp[1] : 'x);
    end
  endtask

  task automatic test_timeout();
    clear_stim();
    sel = 1'b0;
    reqq.push_back(0);
    add_ev(3, 0, 4000);
    add_ev(3, 1, 4000);
    run_window(75);
    checks += 3;
    if (to_cyc != 66) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d want 66", to_cyc);
    end
    if (first_of(val_cyc) != 70) begin
      errors++;
      $display("FAIL timeout_valid_cycle: got %0d want 70",
               first_of(val_cyc));
    end
    if (val_smp.size() == 0 || val_smp[0] !== 18'sd2000) begin
      errors++;
      $display("FAIL timeout_sample: got %0d want 2000",
               (val_smp.size() > 0) ? val_smp[0] : 'x);
    end
    clear_stim();
    reqq.push_back(0);
    for (int v = 0; v < NV; v++) add_ev(3, v, 400);
    run_window(12);
    checks += 2;
    if (val_smp.size() == 0 || val_smp[0] !== 18'sd300) begin
      errors++;
      $display("FAIL timeout_next_sample: got %0d want 300",
               (val_smp.size() > 0) ? val_smp[0] : 'x);
    end
    if (bus.timeout_flag !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b want 1",
               bus.timeout_flag);
    end
  endtask

  task automatic test_reset_mid_sum();
    clear_stim();
    sel = 1'b0;
    reqq.push_back(0);
    for (int v = 0; v < NV; v++) add_ev(2, v, 1000);
    rstq.push_back(4);
    run_window(5);
    checks += 3;
    if (bus.mixed_sample !== '0) begin
      errors++;
      $display("FAIL rst_sum_sample: got %0d want 0",
               bus.mixed_sample);
    end
    if (bus.timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL rst_sum_timeout: got %b want 0",
               bus.timeout_flag);
    end
    clear_stim();
    run_window(10);
    if (val_cyc.size() != 0) begin
      errors++;
      $display("FAIL rst_sum_no_valid: got %0d strobes want 0",
               val_cyc.size());
    end
    clear_stim();
    reqq.push_back(0);
    for (int v = 0; v < NV; v++) add_ev(3, v, 800);
    run_window(12);
    checks += 2;
    if (first_of(val_cyc) != 8) begin
      errors++;
      $display("FAIL rst_after_cycle: got %0d want 8",
               first_of(val_cyc));
    end
    if (val_smp.size() == 0 || val_smp[0] !== 18'sd600) begin
      errors++;
      $display("FAIL rst_after_sample: got %0d want 600",
               (val_smp.size() > 0) ? val_smp[0] : 'x);
    end
  endtask

  task automatic test_silence();
    clear_stim();
    sel = 1'b0;
    play_en = 1'b0;
    reqq.push_back(0);
    for (int v = 0; v < NV; v++) add_ev(1, v, 5000);
    run_window(6);
    checks += 3;
    if (gns_cyc.size() != 0) begin
      errors++;
      $display("FAIL silence_no_gns: got %0d pulses want 0",
               gns_cyc.size());
    end
    if (first_of(val_cyc) != 2) begin
      errors++;
      $display("FAIL silence_valid_cycle: got %0d want 2",
               first_of(val_cyc));
    end
    if (val_smp.size() == 0 || val_smp[0] !== '0) begin
      errors++;
      $display("FAIL silence_sample: got %0d want 0",
               (val_smp.size() > 0) ? val_smp[0] : 'x);
    end
    play_en = 1'b1;
  endtask

  initial begin
    sel = 1'b0;
    u_acc = '0;
    test_reset();
    test_clamp();
    test_nominal();
    test_staggered();
    test_saturation();
    test_back_to_back();
    test_timeout();
    test_reset_mid_sum();
    test_silence();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_sample_mixer.md
Name: voice_sample_mixer

Overview:
- Request-side master for the generate_next / sample_ready handshake used by every sine_reader-based voice and harmonic generator.
- On each codec sample request, it pulses generate_next_sample to all voices and collects each voice's sample_ready/sample pair.
- It then sums the collected samples sequentially, scales and saturates the sum, and presents one 18-bit sample with a one-cycle valid strobe to the codec path.
- It sits between the codec interface and a bank of voice generators.

Parameters:
- NUM_VOICES, 3, number of voice inputs (1..8).
- SAMPLE_W, 18, sample width; signed two's complement.
- SHIFT, 2, arithmetic right shift applied to the sum before saturation.
- TIMEOUT_CYCLES, 64, maximum number of WAIT-state cycles before the block proceeds without the missing voices.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- play_enable  in  1  when low, requests are answered with silence and voices are not requested.
- codec_sample_request  in  1  one-cycle pulse asking for the next output sample.
- generate_next_sample  out  1  one-cycle pulse broadcast to all voices.
- voice_sample_ready  in  NUM_VOICES  per-voice one-cycle ready pulse.
- voice_samples  in  NUM_VOICES*SAMPLE_W  packed samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W]; valid only while the matching ready bit is high.
- mixed_sample  out  SAMPLE_W  mixed output; held between updates.
- mixed_valid  out  1  one-cycle strobe; mixed_sample is new in that cycle.
- overrun  out  1  one-cycle pulse when a request is dropped.
- timeout_flag  out  1  sticky; set when any WAIT state times out.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, capture registers, mask, accumulator and pending flag cleared. Reset asserted mid-operation aborts the operation with no mixed_valid.
- States: IDLE, REQ, WAIT, SUM, SAT, OUT. All outputs are registered and decoded from state.
- IDLE:
  - Request (or pending flag set) with play_enable=1 → REQ.
  - Request with play_enable=0 → OUT, with mixed_sample loaded to 0.
- REQ (1 cycle): generate_next_sample=1; clear capture mask; → WAIT.
- REQ and WAIT both capture samples. In either state, for each voice i with ready high and mask bit i clear: latch its sample and set mask bit i. A repeated ready from an already-captured voice is ignored (first value kept).
- WAIT exit:
  - Mask all ones (including bits set that cycle) → SUM on the next cycle.
  - Otherwise the wait counter increments. When it reaches TIMEOUT_CYCLES: set timeout_flag, → SUM. Uncaptured voices contribute 0.
- SUM: NUM_VOICES cycles, adding one sign-extended capture per cycle, voice 0 first.
  - Accumulator width is SAMPLE_W + clog2(NUM_VOICES) + 1.
  - The accumulator is cleared on entry to REQ.
- SAT (1 cycle):
  - Arithmetic shift of the accumulator right by SHIFT.
  - Clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; load the result into mixed_sample.
  - → OUT.
- OUT (1 cycle): mixed_valid=1; → IDLE.
- Latency: request at cycle 0 gives generate_next_sample at cycle 1. If the mask completes at cycle c, SUM runs cycles c+1..c+NUM_VOICES, SAT at c+NUM_VOICES+1, mixed_valid at c+NUM_VOICES+2.
- Request arriving outside IDLE:
  - If pending is clear, set pending; it is serviced on the next IDLE cycle.
  - If pending is already set, pulse overrun on the next cycle; the request is dropped.
- play_enable dropping mid-operation: the current operation completes normally. It only affects requests evaluated in IDLE.
- voice_sample_ready outside REQ/WAIT: ignored.
- Simultaneous request and reset: reset wins.

Decomposition:
- voice_mixer_pkg holds:
  - SAMPLE_W default;
  - state encoding constants;
  - sample min/max localparams.
- One sub-module, sat_shift_clamp: purely combinational shift plus saturate from accumulator width to SAMPLE_W. It is instantiated in the SAT stage and unit-tested separately.

Test Plan:
1. Nominal mix: NUM_VOICES=3, SHIFT=2. Request at cycle 0; all voices pulse ready at cycle 3 with 4000, 8000, -2000 → generate_next_sample at cycle 1; mixed_sample=2500, mixed_valid at cycle 8, single-cycle.
2. Staggered ready: voice 0 at cycle 2, voice 1 at cycle 5, voice 2 at cycle 9, each carrying 1000; voice 0 pulses again at cycle 6 with 9999 → sum uses 1000 (first value kept); result 750; mixed_valid at cycle 14.
3. Saturation: SHIFT=0, all voices supply 131071 → mixed_sample=131071. All voices supply -131072 → mixed_sample=-131072.
4. Timeout: voice 2 never readies; voices 0 and 1 supply 4000 → timeout_flag set after 64 WAIT cycles and stays 1; mixed_sample=2000; a later normal request does not clear the flag.
5. Back-pressure: requests at cycles 0, 3 and 5 with voices readying at cycle 10 → the cycle-3 request is pended and serviced after OUT; overrun pulses at cycle 6; exactly two mixed_valid strobes.
6. Silence and reset: play_enable=0, request at cycle 0 → no generate_next_sample; mixed_sample=0 with mixed_valid at cycle 2. Reset asserted during SUM → outputs 0, no mixed_valid; the next request completes normally.
